// File: rtl/frame_buffer_controller.sv
// frame_buffer_controller
//   Responder end of the sprite-to-frame-buffer write interface. Two
//   256x256 RGB888 banks live in an external dual-port RAM: pixel writes
//   land in the back bank, the front bank is scanned out as a raster
//   stream, and a dfb request swaps the banks at the next vertical-blank
//   start.
//
//   Optional build macro: FB_AUTOCLEAR_EN -- after each swap, zero-fill
//   the new back bank (65536 writes, one per clock) before returning idle.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   fb_wfb, fb_px            write strobe, pixel address {y, x}
//   fb_r, fb_g, fb_b         pixel colour
//   fb_dfb                   swap request (single-cycle pulse)
//   fb_busy                  swap (and clear) in progress
//   wr_drop                  sticky: a write was discarded during clear
//   ram_wr_en/addr/data      RAM write port, {bank, px} / {r, g, b}
//   ram_rd_addr, ram_rd_data RAM read port, {bank, y, x}, 1-cycle latency
//   disp_valid, disp_rgb     active pixel stream (rgb 0 when not valid)
//   disp_frame_start         pulse with pixel (0,0)
//   disp_vblank              high during the blanking lines
//
// States
//   IDLE    | no swap pending, writes pass through
//   WAIT_VB | swap requested, waiting for vertical-blank start
//   CLEAR   | zero-filling the new back bank (FB_AUTOCLEAR_EN only)

module frame_buffer_controller #(
  parameter int H_BLANK = 64,
  parameter int V_BLANK = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fb_wfb,
  input  logic        fb_dfb,
  input  logic [15:0] fb_px,
  input  logic [7:0]  fb_r,
  input  logic [7:0]  fb_g,
  input  logic [7:0]  fb_b,
  output logic        fb_busy,
  output logic        wr_drop,
  output logic        ram_wr_en,
  output logic [16:0] ram_wr_addr,
  output logic [23:0] ram_wr_data,
  output logic [16:0] ram_rd_addr,
  input  logic [23:0] ram_rd_data,
  output logic        disp_valid,
  output logic [23:0] disp_rgb,
  output logic        disp_frame_start,
  output logic        disp_vblank
);

  localparam int H_TOTAL = 256 + H_BLANK;
  localparam int V_TOTAL = 256 + V_BLANK;
  // +1 keeps at least 9 bits so the "< 256" compares are meaningful.
  localparam int HW = $clog2(H_TOTAL + 1);
  localparam int VW = $clog2(V_TOTAL + 1);
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(256);
  localparam logic [VW-1:0] V_ACT  = VW'(256);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WAIT_VB = 2'd1;
`ifdef FB_AUTOCLEAR_EN
  localparam logic [1:0] S_CLEAR   = 2'd2;
`endif

  logic [1:0]    r_state;
  logic [1:0]    w_state_next;
  logic          r_front_bank;
  logic          r_busy;
  logic          r_wr_drop;
  logic [HW-1:0] r_h_cnt;
  logic [VW-1:0] r_v_cnt;
  logic          r_disp_valid;
  logic          r_disp_frame_start;
  logic          r_disp_vblank;
  logic          w_vb_start;
  logic          w_active;
  logic          w_swap;
  logic          w_drop;
`ifdef FB_AUTOCLEAR_EN
  logic [15:0]   r_clr_cnt;
`endif

  assign w_vb_start = (r_v_cnt == V_ACT) && (r_h_cnt == '0);
  assign w_active   = (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:    if (fb_dfb) w_state_next = S_WAIT_VB;
`ifdef FB_AUTOCLEAR_EN
      S_WAIT_VB: if (w_vb_start) w_state_next = S_CLEAR;
      S_CLEAR:   if (r_clr_cnt == 16'hFFFF) w_state_next = S_IDLE;
`else
      S_WAIT_VB: if (w_vb_start) w_state_next = S_IDLE;
`endif
      default:   w_state_next = S_IDLE;
    endcase
  end

  // Output logic: write-port mux and swap/drop strobes
  always_comb begin
    ram_wr_en   = fb_wfb;
    ram_wr_addr = {~r_front_bank, fb_px};
    ram_wr_data = {fb_r, fb_g, fb_b};
    w_swap      = (r_state == S_WAIT_VB) && w_vb_start;
    w_drop      = 1'b0;
`ifdef FB_AUTOCLEAR_EN
    if (r_state == S_CLEAR) begin
      ram_wr_en   = 1'b1;
      ram_wr_addr = {~r_front_bank, r_clr_cnt};
      ram_wr_data = '0;
      w_drop      = fb_wfb;
    end
`endif
  end

  // Bank select, busy and sticky drop flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_front_bank <= 1'b0;
      r_busy       <= 1'b0;
      r_wr_drop    <= 1'b0;
    end else begin
      if (w_swap) r_front_bank <= ~r_front_bank;
      r_busy <= (w_state_next != S_IDLE);
      if (w_drop) r_wr_drop <= 1'b1;
    end
  end

`ifdef FB_AUTOCLEAR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     r_clr_cnt <= '0;
    else if (r_state == S_CLEAR) r_clr_cnt <= r_clr_cnt + 16'd1;
    else                         r_clr_cnt <= '0;
  end
`endif

  // Raster counters and display flags, delayed one cycle to line up with
  // the RAM read latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_h_cnt            <= '0;
      r_v_cnt            <= '0;
      r_disp_valid       <= 1'b0;
      r_disp_frame_start <= 1'b0;
      r_disp_vblank      <= 1'b0;
    end else begin
      if (r_h_cnt == H_LAST) begin
        r_h_cnt <= '0;
        if (r_v_cnt == V_LAST) r_v_cnt <= '0;
        else                   r_v_cnt <= r_v_cnt + 1'b1;
      end else begin
        r_h_cnt <= r_h_cnt + 1'b1;
      end
      r_disp_valid       <= w_active;
      r_disp_frame_start <= (r_h_cnt == '0) && (r_v_cnt == '0);
      r_disp_vblank      <= (r_v_cnt >= V_ACT);
    end
  end

  assign ram_rd_addr      = {r_front_bank, r_v_cnt[7:0], r_h_cnt[7:0]};
  assign fb_busy          = r_busy;
  assign wr_drop          = r_wr_drop;
  assign disp_valid       = r_disp_valid;
  assign disp_frame_start = r_disp_frame_start;
  assign disp_vblank      = r_disp_vblank;
  assign disp_rgb         = r_disp_valid ? ram_rd_data : 24'h0;

endmodule

// File: tb/tb_frame_buffer_controller.sv
module tb_frame_buffer_controller;

  // Short blanking keeps a full frame plus a swap inside the cycle budget.
  localparam int HB     = 4;
  localparam int VB     = 4;
  localparam int HT     = 256 + HB;
  localparam int VT     = 256 + VB;
  localparam int FRAME  = HT * VT;
  localparam int VB_POS = 256 * HT;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fb_wfb = 1'b0, fb_dfb = 1'b0;
  logic [15:0] fb_px = '0;
  logic [7:0]  fb_r = '0, fb_g = '0, fb_b = '0;
  logic        fb_busy, wr_drop, ram_wr_en;
  logic [16:0] ram_wr_addr, ram_rd_addr;
  logic [23:0] ram_wr_data, ram_rd_data, disp_rgb;
  logic        disp_valid, disp_frame_start, disp_vblank;

  frame_buffer_controller #(.H_BLANK(HB), .V_BLANK(VB)) dut (
    .clk(clk), .rst(rst), .fb_wfb(fb_wfb), .fb_dfb(fb_dfb), .fb_px(fb_px),
    .fb_r(fb_r), .fb_g(fb_g), .fb_b(fb_b), .fb_busy(fb_busy), .wr_drop(wr_drop),
    .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
    .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data), .disp_valid(disp_valid),
    .disp_rgb(disp_rgb), .disp_frame_start(disp_frame_start), .disp_vblank(disp_vblank)
  );

  always #5 clk = ~clk;

  // External dual-port RAM, one-cycle read latency.
  logic [23:0] ram [0:131071];
  always @(posedge clk) begin
    if (ram_wr_en) ram[ram_wr_addr] <= ram_wr_data;
    ram_rd_data <= ram[ram_rd_addr];
  end

  // Clock edges since reset release; cycle "pos" is the one in progress.
  int pos;
  always @(posedge clk or posedge rst) begin
    if (rst) pos <= 0;
    else     pos <= pos + 1;
  end

  typedef struct {
    logic        wfb;
    logic [15:0] px;
    logic [7:0]  r, g, b;
    logic        exp_en;
    logic [16:0] exp_addr;
    logic [23:0] exp_data;
  } vec_t;
  vec_t vecs [5];

  int checks = 0;
  int errors = 0;

  // Reference model: image contents, front bank, pending swap window.
  logic [23:0] exp_mem [0:131071];
  logic        known   [0:131071];
  logic        m_front;
  logic        m_pending;
  int          m_req, m_swap;
  logic [16:0] m_prev_rd;
  int          run_v, run_vb, last_fs;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h want %0h", name, pos, act, exp);
    end
  endtask

  task automatic model_reset();
    m_front   = 1'b0;
    m_pending = 1'b0;
    m_req     = 0;
    m_swap    = 0;
    m_prev_rd = '0;
    run_v     = 0;
    run_vb    = 0;
    last_fs   = -1;
  endtask

  task automatic model_check();
    int q, h, v, hp, vp;
    logic ev, efs, evb, eb;
    logic [16:0] rd, wa;
    q = pos;
    if (m_pending && q == m_swap + 1) begin
      m_front   = ~m_front;
      m_pending = 1'b0;
    end
    h  = q % HT;
    v  = (q / HT) % VT;
    rd = {m_front, 8'(v), 8'(h)};
    chk("rd_addr", 32'(ram_rd_addr), 32'(rd));
    ev = 1'b0; efs = 1'b0; evb = 1'b0;
    if (q > 0) begin
      hp  = (q - 1) % HT;
      vp  = ((q - 1) / HT) % VT;
      ev  = (hp < 256) && (vp < 256);
      efs = ((q - 1) % FRAME) == 0;
      evb = (vp >= 256);
    end
    chk("disp_valid", 32'(disp_valid), 32'(ev));
    chk("frame_start", 32'(disp_frame_start), 32'(efs));
    chk("vblank", 32'(disp_vblank), 32'(evb));
    if (!ev) chk("rgb_blank", 32'(disp_rgb), 32'd0);
    else if (known[m_prev_rd]) chk("rgb", 32'(disp_rgb), 32'(exp_mem[m_prev_rd]));
    eb = m_pending && (q > m_req);
    chk("busy", 32'(fb_busy), 32'(eb));
    chk("wr_drop", 32'(wr_drop), 32'd0);
    wa = {~m_front, fb_px};
    chk("wr_en", 32'(ram_wr_en), 32'(fb_wfb));
    chk("wr_addr", 32'(ram_wr_addr), 32'(wa));
    chk("wr_data", 32'(ram_wr_data), {8'h0, fb_r, fb_g, fb_b});
    if (disp_valid) run_v++;
    else begin
      if (run_v > 0) chk("valid_run", 32'(run_v), 32'd256);
      run_v = 0;
    end
    if (disp_vblank) run_vb++;
    else begin
      if (run_vb > 0) chk("vblank_run", 32'(run_vb), 32'(VB * HT));
      run_vb = 0;
    end
    if (disp_frame_start) begin
      if (last_fs >= 0) chk("fs_period", 32'(q - last_fs), 32'(FRAME));
      last_fs = q;
    end
    if (fb_wfb) begin
      exp_mem[wa] = {fb_r, fb_g, fb_b};
      known[wa]   = 1'b1;
    end
    if (fb_dfb && !m_pending) begin
      m_pending = 1'b1;
      m_req     = q;
      m_swap    = q + 1 + (((VB_POS - (q + 1)) % FRAME) + FRAME) % FRAME;
    end
    m_prev_rd = rd;
  endtask

  task automatic cycle(input logic wfb, input logic dfb, input logic [15:0] px,
                       input logic [23:0] rgb);
    @(negedge clk);
    fb_wfb = wfb; fb_dfb = dfb; fb_px = px;
    fb_r = rgb[23:16]; fb_g = rgb[15:8]; fb_b = rgb[7:0];
    #2;
    model_check();
  endtask

  task automatic rand_cycle(input logic allow_dfb);
    logic [15:0] px;
    px = 16'($urandom);
    if (px == 16'h0A05) px = 16'h0A06;
    cycle($urandom_range(3) == 0, allow_dfb && ($urandom_range(63) == 0),
          px, 24'($urandom));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    fb_wfb = 1'b0; fb_dfb = 1'b0; fb_px = '0; fb_r = '0; fb_g = '0; fb_b = '0;
    repeat (3) @(negedge clk);
    model_reset();
    rst = 1'b0;
    #2;
    chk("rst_busy", 32'(fb_busy), 32'd0);
    chk("rst_drop", 32'(wr_drop), 32'd0);
    chk("rst_wr_en", 32'(ram_wr_en), 32'd0);
    chk("rst_valid", 32'(disp_valid), 32'd0);
    chk("rst_rd_addr", 32'(ram_rd_addr), 32'd0);
    model_check();
  endtask

  initial begin
    vecs[0] = '{1'b1, 16'h0000, 8'h01, 8'h02, 8'h03, 1'b1, 17'h10000, 24'h010203};
    vecs[1] = '{1'b0, 16'hFFFF, 8'hAA, 8'hBB, 8'hCC, 1'b0, 17'h1FFFF, 24'hAABBCC};
    vecs[2] = '{1'b1, 16'hFFFF, 8'h00, 8'h00, 8'h00, 1'b1, 17'h1FFFF, 24'h000000};
    vecs[3] = '{1'b1, 16'h00FF, 8'h12, 8'h34, 8'h56, 1'b1, 17'h100FF, 24'h123456};
    vecs[4] = '{1'b1, 16'h0A05, 8'hFF, 8'h80, 8'h01, 1'b1, 17'h10A05, 24'hFF8001};

    for (int i = 0; i < 131072; i++) known[i] = 1'b0;
    model_reset();

    do_reset();

    // Write path vectors, front bank 0 so writes land in bank 1.
    for (int i = 0; i < 5; i++) begin
      cycle(vecs[i].wfb, 1'b0, vecs[i].px, {vecs[i].r, vecs[i].g, vecs[i].b});
      chk("vec_en", 32'(ram_wr_en), 32'(vecs[i].exp_en));
      chk("vec_addr", 32'(ram_wr_addr), 32'(vecs[i].exp_addr));
      chk("vec_data", 32'(ram_wr_data), 32'(vecs[i].exp_data));
    end

    while (pos < 100 * HT + 36) rand_cycle(1'b0);

    // dfb and wfb together: write goes to the pre-swap back bank.
    cycle(1'b1, 1'b1, 16'h0033, 24'h123456);
    chk("dfb_wfb_addr", 32'(ram_wr_addr), 32'h10033);
    cycle(1'b0, 1'b0, 16'h0, 24'h0);
    chk("busy_after_dfb", 32'(fb_busy), 32'd1);
    repeat (3) cycle(1'b0, 1'b0, 16'h0, 24'h0);
    cycle(1'b0, 1'b1, 16'h0, 24'h0);

    // Further dfb pulses while busy are ignored by the model and the DUT.
    while (pos < VB_POS - 1) rand_cycle(1'b1);
    cycle(1'b0, 1'b0, 16'h0, 24'h0);
    chk("busy_at_vb", 32'(fb_busy), 32'd1);
    chk("rd_at_vb", 32'(ram_rd_addr), 32'h00000);
    cycle(1'b1, 1'b0, 16'h0101, 24'h0000AA);
    chk("busy_after_swap", 32'(fb_busy), 32'd0);
    chk("wr_bank_after_swap", 32'(ram_wr_addr), 32'h00101);
    chk("rd_bank_after_swap", 32'(ram_rd_addr), 32'h10001);

    while (pos < FRAME + 10 * HT + 4) rand_cycle(1'b0);
    cycle(1'b0, 1'b0, 16'h0, 24'h0);
    chk("rd_pixel_5_10", 32'(ram_rd_addr), 32'h10A05);
    cycle(1'b0, 1'b0, 16'h0, 24'h0);
    chk("pixel_5_10_valid", 32'(disp_valid), 32'd1);
    chk("pixel_5_10_rgb", 32'(disp_rgb), 32'hFF8001);

    // Reset in the middle of a pending swap.
    cycle(1'b0, 1'b1, 16'h0, 24'h0);
    repeat (4) cycle(1'b0, 1'b0, 16'h0, 24'h0);
    chk("busy_before_rst", 32'(fb_busy), 32'd1);
    do_reset();
    repeat (20) rand_cycle(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
